// File: rtl/incline_filt.sv
// Exponential moving average of the saturated incline word, plus a clipped unsigned incline factor.
// Optional INCLINE_DEADBAND_EN forces the factor to FACTOR_OFFSET while |avg| < 8.

module incline_filt #(
  parameter int AVG_LOG2      = 4,
  parameter int FACTOR_OFFSET = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vld,
  input  logic       clr,
  input  logic [9:0] incline_sat,
  output logic [9:0] incline_avg,
  output logic [8:0] incline_factor,
  output logic       avg_vld,
  output logic       seeded
);

  // state | meaning
  // SEED  | no history; next accepted sample loads the accumulator directly
  // RUN   | history held; accepted samples update the EMA
  typedef enum logic {SEED = 1'b0, RUN = 1'b1} state_t;

  localparam int AW = 11 + AVG_LOG2;

  localparam logic signed [AW:0]   ACC_MAX = {3'b000, {(9 + AVG_LOG2){1'b1}}};
  localparam logic signed [AW:0]   ACC_MIN = {3'b111, {(9 + AVG_LOG2){1'b0}}};
  localparam logic signed [AW-1:0] AVG_HI  = {{(AW - 9){1'b0}}, {9{1'b1}}};
  localparam logic signed [AW-1:0] AVG_LO  = {{(AW - 9){1'b1}}, {9{1'b0}}};
  localparam logic signed [10:0]   FOFF    = 11'(FACTOR_OFFSET);
  localparam logic        [8:0]    FRST    = 9'(FACTOR_OFFSET);

  state_t state, state_nx;

  logic                 load_seed;
  logic                 load_run;
  logic                 upd_q;
  logic signed [AW-1:0] accum;
  logic signed [AW-1:0] accum_nx;

  logic signed [AW:0]   acc_x;
  logic signed [AW:0]   dec_x;
  logic signed [AW:0]   smp_x;
  logic signed [AW:0]   seed_x;
  logic signed [AW:0]   sum_x;

  logic signed [AW-1:0] avg_w;
  logic signed [9:0]    avg10;
  logic signed [9:0]    avg_f;
  logic signed [10:0]   f11;
  logic        [8:0]    factor_nx;

  // ---------------- controller ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SEED;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (clr)
      state_nx = SEED;
    else if (vld && state == SEED)
      state_nx = RUN;
  end

  always_comb begin
    load_seed = 1'b0;
    load_run  = 1'b0;
    if (vld && !clr) begin
      if (state == SEED) load_seed = 1'b1;
      else               load_run  = 1'b1;
    end
    seeded = (state == RUN);
  end

  // ---------------- accumulator ----------------
  always_comb begin
    acc_x    = {accum[AW-1], accum};
    dec_x    = acc_x >>> AVG_LOG2;
    smp_x    = {{(AW - 9){incline_sat[9]}}, incline_sat};
    seed_x   = smp_x <<< AVG_LOG2;
    sum_x    = acc_x - dec_x + smp_x;
    accum_nx = accum;
    if (load_seed) begin
      accum_nx = seed_x[AW-1:0];
    end else if (load_run) begin
      if (sum_x > ACC_MAX)      accum_nx = ACC_MAX[AW-1:0];
      else if (sum_x < ACC_MIN) accum_nx = ACC_MIN[AW-1:0];
      else                      accum_nx = sum_x[AW-1:0];
    end
  end

  // upd_q marks an accumulator update whose result the output stage publishes next edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accum <= '0;
      upd_q <= 1'b0;
    end else begin
      accum <= accum_nx;
      upd_q <= load_seed | load_run;
    end
  end

  // ---------------- output stage ----------------
  always_comb begin
    avg_w = accum >>> AVG_LOG2;
    if (avg_w > AVG_HI)      avg10 = 10'sd511;
    else if (avg_w < AVG_LO) avg10 = -10'sd512;
    else                     avg10 = avg_w[9:0];

`ifdef INCLINE_DEADBAND_EN
    if (avg10 >= -10'sd7 && avg10 <= 10'sd7) avg_f = '0;
    else                                      avg_f = avg10;
`else
    avg_f = avg10;
`endif

    f11 = {avg_f[9], avg_f} + FOFF;
    if (f11 < 11'sd0)        factor_nx = 9'd0;
    else if (f11 > 11'sd511) factor_nx = 9'd511;
    else                     factor_nx = f11[8:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      incline_avg    <= '0;
      incline_factor <= FRST;
      avg_vld        <= 1'b0;
    end else begin
      avg_vld <= upd_q;
      if (upd_q) begin
        incline_avg    <= avg10;
        incline_factor <= factor_nx;
      end
    end
  end

endmodule
